// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge: converts a valid/ready register request into one APB4 transfer with optional access timeout.
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_valid, i_address, i_write,
//   i_write_data, i_strobe            request (held stable until o_ready)
//   o_ready, o_read_data, o_status    one-cycle response (00 OKAY, 10 SLAVE_ERROR, 11 timeout)
//   o_psel, o_penable, o_pwrite,
//   o_paddr, o_pprot, o_pstrb,
//   o_pwdata                          APB requester outputs (all registered)
//   i_pready, i_pslverr, i_prdata     APB completer response, sampled only in ACCESS
module rggen_apb_bridge #(
    parameter int         ADDRESS_WIDTH = 8,
    parameter int         BUS_WIDTH     = 32,
    parameter int         TIMEOUT       = 0,
    parameter logic [2:0] PPROT         = 3'b000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic [ADDRESS_WIDTH-1:0]   i_address,
    input  logic                       i_write,
    input  logic [BUS_WIDTH-1:0]       i_write_data,
    input  logic [BUS_WIDTH/8-1:0]     i_strobe,
    output logic                       o_ready,
    output logic [BUS_WIDTH-1:0]       o_read_data,
    output logic [1:0]                 o_status,
    output logic                       o_psel,
    output logic                       o_penable,
    output logic                       o_pwrite,
    output logic [ADDRESS_WIDTH-1:0]   o_paddr,
    output logic [2:0]                 o_pprot,
    output logic [BUS_WIDTH/8-1:0]     o_pstrb,
    output logic [BUS_WIDTH-1:0]       o_pwdata,
    input  logic                       i_pready,
    input  logic                       i_pslverr,
    input  logic [BUS_WIDTH-1:0]       i_prdata
);
    localparam int SW = BUS_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam logic [ADDRESS_WIDTH-1:0] AMASK = ~ADDRESS_WIDTH'((1 << LSB) - 1);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_t;

    state_t                     state_q, state_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       pwrite_q, pwrite_d;
    logic [ADDRESS_WIDTH-1:0]   paddr_q, paddr_d;
    logic [2:0]                 pprot_q, pprot_d;
    logic [SW-1:0]              pstrb_q, pstrb_d;
    logic [BUS_WIDTH-1:0]       pwdata_q, pwdata_d;
    logic                       ready_q, ready_d;
    logic [BUS_WIDTH-1:0]       rdata_q, rdata_d;
    logic [1:0]                 status_q, status_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        ready_d   = 1'b0;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pprot_d   = pprot_q;
        pstrb_d   = pstrb_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        status_d  = status_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                // RESPONSE always passes through IDLE, so a request still held
                // during o_ready can never be accepted twice.
                if (i_valid) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = i_write;
                    paddr_d  = i_address & AMASK;
                    pprot_d  = PPROT;
                    pstrb_d  = i_write ? i_strobe : '0;
                    pwdata_d = i_write ? i_write_data : '0;
                    cnt_d    = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (i_pready) begin
                    state_d  = RESPONSE;
                    ready_d  = 1'b1;
                    rdata_d  = pwrite_q ? '0 : i_prdata;
                    status_d = i_pslverr ? 2'b10 : 2'b00;
                end else if (TIMEOUT > 0 && cnt_q == LAST) begin
                    // Abort mid-transfer; the completer sees PSEL drop without PREADY.
                    state_d  = RESPONSE;
                    ready_d  = 1'b1;
                    rdata_d  = '0;
                    status_d = 2'b11;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            RESPONSE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pstrb_q   <= '0;
            pwdata_q  <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            status_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pprot_q   <= pprot_d;
            pstrb_q   <= pstrb_d;
            pwdata_q  <= pwdata_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            status_q  <= status_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_psel      = psel_q;
    assign o_penable   = penable_q;
    assign o_pwrite    = pwrite_q;
    assign o_paddr     = paddr_q;
    assign o_pprot     = pprot_q;
    assign o_pstrb     = pstrb_q;
    assign o_pwdata    = pwdata_q;
    assign o_ready     = ready_q;
    assign o_read_data = rdata_q;
    assign o_status    = status_q;
endmodule

// File: tb/tb_rggen_apb_bridge.sv
// tb_rggen_apb_bridge: directed self-checking bench for rggen_apb_bridge (TIMEOUT=4, PPROT=101).
module tb_rggen_apb_bridge;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [7:0]  i_address = '0;
    logic        i_write = 1'b0;
    logic [31:0] i_write_data = '0;
    logic [3:0]  i_strobe = '0;
    logic        o_ready;
    logic [31:0] o_read_data;
    logic [1:0]  o_status;
    logic        o_psel, o_penable, o_pwrite;
    logic [7:0]  o_paddr;
    logic [2:0]  o_pprot;
    logic [3:0]  o_pstrb;
    logic [31:0] o_pwdata;
    logic        i_pready = 1'b0;
    logic        i_pslverr = 1'b0;
    logic [31:0] i_prdata = '0;

    int total = 0;
    int bad = 0;

    int          idle_n, setup_n, access_n;
    logic [31:0] rd, pwd;
    logic [1:0]  st;
    logic [7:0]  pa;
    logic [3:0]  ps_or;
    logic [2:0]  pp;
    logic        pw, psel_r, unstable, done;

    rggen_apb_bridge #(
        .ADDRESS_WIDTH(8),
        .BUS_WIDTH(32),
        .TIMEOUT(4),
        .PPROT(3'b101)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_valid), .i_address(i_address), .i_write(i_write),
        .i_write_data(i_write_data), .i_strobe(i_strobe),
        .o_ready(o_ready), .o_read_data(o_read_data), .o_status(o_status),
        .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
        .o_paddr(o_paddr), .o_pprot(o_pprot), .o_pstrb(o_pstrb), .o_pwdata(o_pwdata),
        .i_pready(i_pready), .i_pslverr(i_pslverr), .i_prdata(i_prdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Drives one request and plays the completer: PREADY rises on ACCESS cycle waits+1.
    // PREADY/PSLVERR are also raised during SETUP, where the bridge must ignore them.
    task automatic xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] sb, input int waits, input logic err,
                        input logic [31:0] rdin, input logic hold);
        logic [3:0] ps0;
        idle_n = 0; setup_n = 0; access_n = 0;
        rd = '0; st = '0; pa = '0; ps_or = '0; pp = '0; pw = 1'b0; pwd = '0;
        psel_r = 1'b1; unstable = 1'b0; done = 1'b0; ps0 = '0;
        i_valid = 1'b1; i_address = addr; i_write = wr; i_write_data = wd;
        i_strobe = sb; i_prdata = rdin; i_pready = 1'b0; i_pslverr = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (o_ready) begin
                rd = o_read_data; st = o_status; psel_r = o_psel; done = 1'b1;
                i_pready = 1'b0; i_pslverr = 1'b0;
                if (!hold) i_valid = 1'b0;
            end else if (o_psel && !o_penable) begin
                setup_n++;
                pa = o_paddr; pw = o_pwrite; pwd = o_pwdata; pp = o_pprot; ps0 = o_pstrb;
                ps_or |= o_pstrb;
                i_pready = 1'b1; i_pslverr = 1'b1;
            end else if (o_psel && o_penable) begin
                access_n++;
                ps_or |= o_pstrb;
                if (o_paddr !== pa || o_pwrite !== pw || o_pwdata !== pwd || o_pstrb !== ps0 || o_pprot !== pp)
                    unstable = 1'b1;
                i_pready = (access_n == waits + 1);
                i_pslverr = err && i_pready;
            end else begin
                idle_n++;
                i_pready = 1'b0; i_pslverr = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        #23;
        total++; if ({o_psel, o_penable, o_pwrite, o_ready} !== 4'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=0000", {o_psel, o_penable, o_pwrite, o_ready}); end
        total++; if ({o_paddr, o_pstrb, o_pwdata} !== 44'h0) begin bad++; $display("FAIL rst_apb_data got=%h want=0", {o_paddr, o_pstrb, o_pwdata}); end
        total++; if ({o_read_data, o_status, o_pprot} !== 37'h0) begin bad++; $display("FAIL rst_resp got=%h want=0", {o_read_data, o_status, o_pprot}); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic test_zero_wait_write;
        xfer(8'h13, 1'b1, 32'hDEADBEEF, 4'b0101, 0, 1'b0, 32'h5555AAAA, 1'b0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wr0_done got=%b want=1", done); end
        total++; if (setup_n !== 1 || access_n !== 1) begin bad++; $display("FAIL wr0_phases got=%0d/%0d want=1/1", setup_n, access_n); end
        total++; if (pa !== 8'h10) begin bad++; $display("FAIL wr0_paddr got=%h want=10", pa); end
        total++; if (ps_or !== 4'b0101) begin bad++; $display("FAIL wr0_pstrb got=%b want=0101", ps_or); end
        total++; if (pw !== 1'b1 || pwd !== 32'hDEADBEEF) begin bad++; $display("FAIL wr0_pwrite_pwdata got=%b/%h want=1/deadbeef", pw, pwd); end
        total++; if (pp !== 3'b101) begin bad++; $display("FAIL wr0_pprot got=%b want=101", pp); end
        total++; if (st !== 2'b00 || rd !== 32'h0) begin bad++; $display("FAIL wr0_resp got=%b/%h want=00/0", st, rd); end
        total++; if (unstable !== 1'b0) begin bad++; $display("FAIL wr0_stable got=%b want=0", unstable); end
        tick();
        total++; if (o_ready !== 1'b0 || o_psel !== 1'b0) begin bad++; $display("FAIL wr0_single_pulse got=%b%b want=00", o_ready, o_psel); end
    endtask

    task automatic test_read_waits;
        xfer(8'h27, 1'b0, 32'hFFFFFFFF, 4'b1111, 3, 1'b0, 32'h12345678, 1'b0);
        total++; if (done !== 1'b1 || access_n !== 4) begin bad++; $display("FAIL rd3_access got=%b/%0d want=1/4", done, access_n); end
        total++; if (rd !== 32'h12345678 || st !== 2'b00) begin bad++; $display("FAIL rd3_resp got=%h/%b want=12345678/00", rd, st); end
        total++; if (ps_or !== 4'b0 || pwd !== 32'h0 || pw !== 1'b0) begin bad++; $display("FAIL rd3_apb got=%b/%h/%b want=0000/0/0", ps_or, pwd, pw); end
        total++; if (pa !== 8'h24 || unstable !== 1'b0) begin bad++; $display("FAIL rd3_addr got=%h/%b want=24/0", pa, unstable); end
    endtask

    task automatic test_back_to_back;
        xfer(8'h08, 1'b1, 32'h0000CAFE, 4'b0011, 1, 1'b1, 32'h0, 1'b1);
        total++; if (st !== 2'b10 || rd !== 32'h0 || access_n !== 2) begin bad++; $display("FAIL err_resp got=%b/%h/%0d want=10/0/2", st, rd, access_n); end
        xfer(8'h0C, 1'b0, 32'h0, 4'b0, 0, 1'b0, 32'hA5A50F0F, 1'b0);
        total++; if (idle_n !== 1) begin bad++; $display("FAIL b2b_idle got=%0d want=1", idle_n); end
        total++; if (setup_n !== 1 || pw !== 1'b0 || pa !== 8'h0C) begin bad++; $display("FAIL b2b_setup got=%0d/%b/%h want=1/0/0c", setup_n, pw, pa); end
        total++; if (rd !== 32'hA5A50F0F || st !== 2'b00) begin bad++; $display("FAIL b2b_resp got=%h/%b want=a5a50f0f/00", rd, st); end
        setup_n = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (o_psel || o_ready) setup_n++;
        end
        total++; if (setup_n !== 0) begin bad++; $display("FAIL b2b_no_dup got=%0d want=0", setup_n); end
    endtask

    task automatic test_timeout;
        xfer(8'h30, 1'b0, 32'h0, 4'b0, 100, 1'b0, 32'hFFFFFFFF, 1'b0);
        total++; if (done !== 1'b1 || access_n !== 4) begin bad++; $display("FAIL to_access got=%b/%0d want=1/4", done, access_n); end
        total++; if (st !== 2'b11 || rd !== 32'h0) begin bad++; $display("FAIL to_resp got=%b/%h want=11/0", st, rd); end
        total++; if (psel_r !== 1'b0 || o_penable !== 1'b0) begin bad++; $display("FAIL to_psel_drop got=%b%b want=00", psel_r, o_penable); end
        xfer(8'h34, 1'b1, 32'h01020304, 4'b1000, 3, 1'b0, 32'h0, 1'b0);
        total++; if (access_n !== 4 || st !== 2'b00 || rd !== 32'h0) begin bad++; $display("FAIL to_edge_ready got=%0d/%b/%h want=4/00/0", access_n, st, rd); end
    endtask

    task automatic test_reset_mid_access;
        i_valid = 1'b1; i_address = 8'h44; i_write = 1'b0; i_pready = 1'b0; i_pslverr = 1'b0;
        tick(); tick(); tick();
        total++; if (o_psel !== 1'b1 || o_penable !== 1'b1) begin bad++; $display("FAIL mid_in_access got=%b%b want=11", o_psel, o_penable); end
        #2 i_rst = 1'b1;
        #1;
        total++; if (o_psel !== 1'b0 || o_penable !== 1'b0) begin bad++; $display("FAIL mid_async_drop got=%b%b want=00", o_psel, o_penable); end
        i_valid = 1'b0;
        setup_n = 0;
        tick(); tick();
        i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (o_psel || o_ready) setup_n++;
        end
        total++; if (setup_n !== 0) begin bad++; $display("FAIL mid_no_ready got=%0d want=0", setup_n); end
        xfer(8'h4B, 1'b0, 32'h0, 4'b0, 1, 1'b0, 32'hCAFEF00D, 1'b0);
        total++; if (done !== 1'b1 || rd !== 32'hCAFEF00D || st !== 2'b00 || pa !== 8'h48) begin bad++; $display("FAIL mid_recover got=%b/%h/%b/%h want=1/cafef00d/00/48", done, rd, st, pa); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_waits();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
